// File: rtl/lutram_march_ctrl.sv
// March C- BIST controller for one single-port, async-read distributed RAM.
// Drives the RAM directly, compares every read, and records the first failure.
module lutram_march_ctrl #(
  parameter int unsigned A_WIDTH = 8,
  parameter int unsigned ERR_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  output logic [A_WIDTH-1:0] ram_a_o,
  output logic               ram_d_o,
  output logic               ram_we_o,
  input  logic               ram_q_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [ERR_W-1:0]   err_count_o,
  output logic [A_WIDTH-1:0] fail_addr_o,
  output logic [2:0]         fail_elem_o,
  output logic               fail_seen_o
);

  localparam logic [A_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [ERR_W-1:0]   ERR_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DONE
  } state_e;

  typedef enum logic {PH_RD, PH_WR} phase_e;

  state_e               state_q, state_d;
  phase_e               phase_q, phase_d;
  logic [A_WIDTH-1:0]   addr_q, addr_d;
  logic [ERR_W-1:0]     err_q, err_d;
  logic [A_WIDTH-1:0]   fail_addr_q, fail_addr_d;
  logic [2:0]           fail_elem_q, fail_elem_d;
  logic                 fail_seen_q, fail_seen_d;

  logic                 busy_c, march_c, down_c, rd_c, we_c, wval_c, exp_c;
  logic                 last_op_c, at_term_c;
  logic [2:0]           elem_c;
  logic [A_WIDTH-1:0]   step_c;

  // State and result registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      phase_q     <= PH_RD;
      addr_q      <= '0;
      err_q       <= '0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      fail_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      fail_seen_q <= fail_seen_d;
    end
  end

  // Next-state, RAM decode and compare
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    addr_d      = addr_q;
    err_d       = err_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    fail_seen_d = fail_seen_q;

    busy_c    = state_q inside {S_M0, S_M1, S_M2, S_M3, S_M4, S_M5};
    march_c   = state_q inside {S_M1, S_M2, S_M3, S_M4};
    down_c    = state_q inside {S_M3, S_M4};
    rd_c      = (march_c && (phase_q == PH_RD)) || (state_q == S_M5);
    we_c      = (march_c && (phase_q == PH_WR)) || (state_q == S_M0);
    wval_c    = state_q inside {S_M1, S_M3};
    exp_c     = state_q inside {S_M2, S_M4};
    last_op_c = (state_q inside {S_M0, S_M5}) || (march_c && (phase_q == PH_WR));
    at_term_c = down_c ? (addr_q == '0) : (addr_q == ADDR_MAX);
    step_c    = down_c ? (addr_q - A_WIDTH'(1)) : (addr_q + A_WIDTH'(1));

    elem_c = 3'd0;
    case (state_q)
      S_M1:    elem_c = 3'd1;
      S_M2:    elem_c = 3'd2;
      S_M3:    elem_c = 3'd3;
      S_M4:    elem_c = 3'd4;
      S_M5:    elem_c = 3'd5;
      default: elem_c = 3'd0;
    endcase

    if (!busy_c) begin
      if (start_i) begin
        state_d     = S_M0;
        phase_d     = PH_RD;
        addr_d      = '0;
        err_d       = '0;
        fail_addr_d = '0;
        fail_elem_d = '0;
        fail_seen_d = 1'b0;
      end
    end else begin
      if (march_c) begin
        phase_d = (phase_q == PH_RD) ? PH_WR : PH_RD;
      end
      if (last_op_c) begin
        if (at_term_c) begin
          phase_d = PH_RD;
          case (state_q)
            S_M0:    begin state_d = S_M1;   addr_d = '0;       end
            S_M1:    begin state_d = S_M2;   addr_d = '0;       end
            S_M2:    begin state_d = S_M3;   addr_d = ADDR_MAX; end
            S_M3:    begin state_d = S_M4;   addr_d = ADDR_MAX; end
            S_M4:    begin state_d = S_M5;   addr_d = '0;       end
            default: begin state_d = S_DONE; addr_d = '0;       end
          endcase
        end else begin
          addr_d = step_c;
        end
      end
      // Read data is sampled at the edge that closes the read cycle
      if (rd_c && (ram_q_i != exp_c)) begin
        if (err_q != ERR_MAX) begin
          err_d = err_q + ERR_W'(1);
        end
        if (!fail_seen_q) begin
          fail_seen_d = 1'b1;
          fail_addr_d = addr_q;
          fail_elem_d = elem_c;
        end
      end
    end

    ram_a_o  = busy_c ? addr_q : '0;
    ram_we_o = we_c;
    ram_d_o  = we_c & wval_c;
  end

  assign busy_o      = busy_c;
  assign done_o      = (state_q == S_DONE);
  assign pass_o      = (state_q == S_DONE) && (err_q == '0);
  assign err_count_o = err_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_elem_o = fail_elem_q;
  assign fail_seen_o = fail_seen_q;

endmodule

// File: tb/tb_lutram_march_ctrl.sv
// Directed bench for lutram_march_ctrl with a behavioural RAM256X1S and
// injectable stuck-at cells.
module tb_lutram_march_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  ram_a;
  logic        ram_d, ram_we, ram_q;
  logic        busy, done, pass, fail_seen;
  logic [15:0] err_count;
  logic [7:0]  fail_addr;
  logic [2:0]  fail_elem;

  logic        mem [0:255];
  logic        sa1_en = 1'b0, sa0_en = 1'b0;
  logic [7:0]  sa1_addr = 8'h00, sa0_addr = 8'h00;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lutram_march_ctrl #(.A_WIDTH(8), .ERR_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .ram_a_o(ram_a), .ram_d_o(ram_d), .ram_we_o(ram_we), .ram_q_i(ram_q),
    .busy_o(busy), .done_o(done), .pass_o(pass), .err_count_o(err_count),
    .fail_addr_o(fail_addr), .fail_elem_o(fail_elem), .fail_seen_o(fail_seen)
  );

  always @(posedge clk) if (ram_we) mem[ram_a] <= ram_d;

  assign ram_q = (sa1_en && ram_a == sa1_addr) ? 1'b1 :
                 (sa0_en && ram_a == sa0_addr) ? 1'b0 : mem[ram_a];

  // Runs from the current negedge until done_o, counting busy/write/read cycles.
  task automatic measure(input bit toggle, output int bcyc, output int wr,
                         output int rd, output logic [7:0] a_m3, output bit to);
    bcyc = 0; wr = 0; rd = 0; a_m3 = 8'h00; to = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (done) begin
        to = 1'b0;
        break;
      end
      if (busy) begin
        if (bcyc == 1280) a_m3 = ram_a;
        bcyc++;
        if (ram_we) wr++; else rd++;
      end
      if (toggle) start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [40:0] outs;
    rst = 1'b1; start = 1'b0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (i == 3) rst = 1'b0;
      if (i >= 1) begin
        outs = {busy, done, pass, fail_seen, err_count, fail_addr, fail_elem, ram_a, ram_d, ram_we};
        checks++;
        if (outs !== 41'd0) begin
          errors++;
          $display("FAIL reset_idle cycle %0d: outputs=%h required 0", i, outs);
        end
      end
    end
  endtask

  task automatic test_fault_free();
    int bc, wr, rd; logic [7:0] am3; bit to;
    do_reset();
    pulse_start();
    checks++;
    if ({busy, ram_we, ram_a} !== {1'b1, 1'b1, 8'h00}) begin
      errors++;
      $display("FAIL start_edge: busy=%b we=%b a=%h required 1 1 00", busy, ram_we, ram_a);
    end
    measure(1'b0, bc, wr, rd, am3, to);
    checks++;
    if (to) begin errors++; $display("FAIL ff_timeout: done never seen"); end
    checks++;
    if (bc != 2560) begin errors++; $display("FAIL ff_busy_cycles: got %0d required 2560", bc); end
    checks++;
    if (wr != 1280 || rd != 1280) begin
      errors++; $display("FAIL ff_ops: writes %0d reads %0d required 1280 1280", wr, rd);
    end
    checks++;
    if (am3 !== 8'hFF) begin errors++; $display("FAIL ff_m3_first_addr: got %h required ff", am3); end
    checks++;
    if ({done, pass, busy, err_count, fail_seen} !== {1'b1, 1'b1, 1'b0, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL ff_result: done=%b pass=%b busy=%b err=%0d seen=%b required 1 1 0 0 0",
               done, pass, busy, err_count, fail_seen);
    end
  endtask

  task automatic test_stuck_at1();
    int bc, wr, rd; logic [7:0] am3; bit to;
    do_reset();
    sa1_en = 1'b1; sa1_addr = 8'h5A;
    pulse_start();
    measure(1'b0, bc, wr, rd, am3, to);
    checks++;
    if (to) begin errors++; $display("FAIL sa1_timeout: done never seen"); end
    checks++;
    if (err_count !== 16'd3) begin errors++; $display("FAIL sa1_err_count: got %0d required 3", err_count); end
    checks++;
    if (fail_addr !== 8'h5A || fail_elem !== 3'd1 || fail_seen !== 1'b1) begin
      errors++;
      $display("FAIL sa1_first: addr=%h elem=%0d seen=%b required 5a 1 1", fail_addr, fail_elem, fail_seen);
    end
    checks++;
    if (pass !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL sa1_pass: pass=%b done=%b required 0 1", pass, done);
    end
    sa1_en = 1'b0;
  endtask

  task automatic test_stuck_at0();
    int bc, wr, rd; logic [7:0] am3; bit to;
    do_reset();
    sa0_en = 1'b1; sa0_addr = 8'hFF;
    pulse_start();
    measure(1'b0, bc, wr, rd, am3, to);
    checks++;
    if (to) begin errors++; $display("FAIL sa0_timeout: done never seen"); end
    checks++;
    if (err_count !== 16'd2) begin errors++; $display("FAIL sa0_err_count: got %0d required 2", err_count); end
    checks++;
    if (fail_addr !== 8'hFF || fail_elem !== 3'd2 || pass !== 1'b0) begin
      errors++;
      $display("FAIL sa0_first: addr=%h elem=%0d pass=%b required ff 2 0", fail_addr, fail_elem, pass);
    end
    sa0_en = 1'b0;
  endtask

  task automatic test_start_held();
    int bc, wr, rd; logic [7:0] am3; bit to;
    do_reset();
    sa1_en = 1'b1; sa1_addr = 8'h5A;
    start = 1'b1;
    @(negedge clk);
    measure(1'b1, bc, wr, rd, am3, to);
    start = 1'b1;
    checks++;
    if (to || bc != 2560) begin
      errors++; $display("FAIL held_run_length: got %0d timeout=%b required 2560", bc, to);
    end
    checks++;
    if (err_count !== 16'd3) begin errors++; $display("FAIL held_err_before: got %0d required 3", err_count); end
    @(negedge clk);
    checks++;
    if ({busy, done, ram_we, ram_a, err_count, fail_seen, fail_addr, fail_elem} !==
        {1'b1, 1'b0, 1'b1, 8'h00, 16'd0, 1'b0, 8'h00, 3'd0}) begin
      errors++;
      $display("FAIL held_restart: busy=%b done=%b we=%b a=%h err=%0d seen=%b required 1 0 1 00 0 0",
               busy, done, ram_we, ram_a, err_count, fail_seen);
    end
    sa1_en = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int bc, wr, rd; logic [7:0] am3; bit to;
    do_reset();
    sa1_en = 1'b1; sa1_addr = 8'h5A;
    pulse_start();
    repeat (772) @(negedge clk);
    checks++;
    if (err_count !== 16'd1 || ram_we !== 1'b0 || ram_a !== 8'h02) begin
      errors++;
      $display("FAIL midrun_pre: err=%0d we=%b a=%h required 1 0 02", err_count, ram_we, ram_a);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, ram_we, ram_a, ram_d, err_count, fail_seen, fail_addr, fail_elem} !== 40'd0) begin
      errors++;
      $display("FAIL midrun_reset: busy=%b done=%b we=%b a=%h err=%0d seen=%b required all 0",
               busy, done, ram_we, ram_a, err_count, fail_seen);
    end
    sa1_en = 1'b0;
    @(negedge clk);
    pulse_start();
    measure(1'b0, bc, wr, rd, am3, to);
    checks++;
    if (to || pass !== 1'b1 || bc != 2560) begin
      errors++; $display("FAIL midrun_rerun: pass=%b cycles=%0d timeout=%b required 1 2560 0", pass, bc, to);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 1'b0;
    test_reset();
    test_fault_free();
    test_stuck_at1();
    test_stuck_at0();
    test_start_held();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lutram_march_ctrl.md
# lutram_march_ctrl

March C- built-in self-test controller for one single-port, asynchronous-read distributed RAM primitive (RAM256X1S class: shared A, D in, WE, O out, write on clock edge). It drives the RAM's address, data and write enable directly, compares every read against the expected value, and reports pass/fail, the error count and the first failing address and element. It sits in the lutram test harness between the divided test clock domain and the DUT RAM, replacing the ad-hoc clear/write/read sequencer.

## Interface
Parameters:
- A_WIDTH, 8, RAM address width; depth N = 2**A_WIDTH.
- ERR_W, 16, error counter width; the counter saturates.

Ports:
- clk_i  in  1  single clock; must also drive the RAM WCLK.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  level; sampled only in IDLE and DONE.
- ram_a_o  out  A_WIDTH  RAM address.
- ram_d_o  out  1  RAM write data.
- ram_we_o  out  1  RAM write enable.
- ram_q_i  in  1  RAM asynchronous read data (O).
- busy_o  out  1  test in progress.
- done_o  out  1  test complete; results valid.
- pass_o  out  1  done_o and zero errors.
- err_count_o  out  ERR_W  saturating mismatch count.
- fail_addr_o  out  A_WIDTH  address of the first mismatch.
- fail_elem_o  out  3  march element (1..5) of the first mismatch.
- fail_seen_o  out  1  at least one mismatch seen.

## Operation
- States: IDLE, M0, M1, M2, M3, M4, M5, DONE. Elements M1-M4 use a phase bit, RD then WR.
- M0 ⇑ w0. M1 ⇑ (r0, w1). M2 ⇑ (r1, w0). M3 ⇓ (r0, w1). M4 ⇓ (r1, w0). M5 ⇑ r0.
- ⇑ means the address runs 0 to N-1. ⇓ means it runs N-1 down to 0.
- Address register: loaded with 0 (⇑) or N-1 (⇓) on entry to each element.
- The address advances after the last operation at the current address. It steps after WR in M1-M4, and every cycle in M0 and M5.
- End of element: the last operation at the terminal address (N-1 for ⇑, 0 for ⇓). No wrap past the terminal address.
- ram_a_o, ram_d_o and ram_we_o are decoded combinationally from registered state, phase and address.
- ram_we_o = 1 only in M0 and in WR phases. ram_d_o is the element's write value, 0 in every non-write cycle.
- Compare: in each read cycle, ram_q_i is compared with the expected value at the closing clock edge.
- On a mismatch, err_count_o increments, saturating at 2**ERR_W-1.
- On the first mismatch only, fail_addr_o and fail_elem_o are captured and fail_seen_o is set.
- IDLE: all RAM outputs 0. When start_i = 1, go to M0 and clear every result register.
- DONE: done_o = 1. Results hold. When start_i = 1, restart exactly as from IDLE.
- Any start_i value while busy is ignored.
- Arithmetic: address counts modulo 2**A_WIDTH. Terminal-address detection uses an equality compare.

## Timing
- Reset values: state IDLE and all outputs 0, including ram_we_o, ram_a_o and ram_d_o. err_count_o = 0.
- rst_i takes effect at the next edge in any state. ram_we_o is 0 from that edge on, so no partial writes are issued after reset.
- Start edge (IDLE, start_i = 1): in the next cycle, busy_o = 1, ram_a_o = 0 and ram_we_o = 1.
- Cycle budget: M0 N, M1-M4 2N each, M5 N. Total 10N cycles with busy_o = 1 (2560 at default).
- After the edge that ends the final M5 read, busy_o = 0 and done_o = 1 in the same cycle. pass_o is valid from that cycle.
- The error from the last M5 read is already included in the results at that cycle.
- Operation counts per run: 5N writes and 5N reads (1280 each at default).
- Read latency contract: ram_q_i must settle within one clock period of ram_a_o changing; there are no registered read stages.

## Test plan
- Reset and idle: hold rst_i 3 cycles, then idle 10 cycles. Required: all outputs 0 and ram_we_o never 1.
- Fault-free behavioural RAM, 1-cycle start_i pulse. Required:
  - busy_o for exactly 2560 cycles, then done_o = 1, pass_o = 1, err_count_o = 0;
  - exactly 1280 write and 1280 read cycles;
  - the first M3 access is at address 0xFF.
- Stuck-at-1 at address 0x5A. Required: err_count_o = 3 (M1, M3, M5 reads), fail_addr_o = 0x5A, fail_elem_o = 1, pass_o = 0.
- Stuck-at-0 at address 0xFF. Required: err_count_o = 2 (M2, M4), fail_addr_o = 0xFF, fail_elem_o = 2.
- start_i held high throughout. Required:
  - mid-run toggling of start_i has no effect and the run length stays 2560;
  - in DONE, the next cycle restarts with results cleared.
- rst_i pulse in the 5th cycle of M2. Required:
  - the next cycle is IDLE with ram_we_o = 0 and results cleared;
  - a fresh start on a fault-free RAM gives pass_o = 1.
